key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 5, number of independent key channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, stable-sample count required to accept a level change (20 ms at 50 MHz).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 = key pressed when pin low, 0 = pressed when pin high.
REQ-004 SHALL have parameter REPEAT_DELAY, default 25_000_000, hold time before first auto-repeat (used only with KEY_DEBOUNCE_REPEAT_EN).
REQ-005 SHALL have parameter REPEAT_PERIOD, default 5_000_000, interval between auto-repeat pulses (used only with KEY_DEBOUNCE_REPEAT_EN).
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 key_in  input  NUM_KEYS  raw asynchronous key pins.
REQ-009 key_level  output  NUM_KEYS  debounced state, 1 = pressed, independent of ACTIVE_LOW.
REQ-010 key_press  output  NUM_KEYS  one-clock pulse per accepted press (and per repeat when enabled).
REQ-011 key_release  output  NUM_KEYS  one-clock pulse per accepted release.

Function
REQ-012 Each key_in bit SHALL pass through a 3-flop synchronizer; bit [2] is the sampled value, polarity-normalised by ACTIVE_LOW.
REQ-013 Each channel SHALL run FSM IDLE -> PRESS_WAIT -> HELD -> RELEASE_WAIT -> IDLE.
REQ-014 IDLE: on sampled pressed, go PRESS_WAIT with counter cleared.
REQ-015 PRESS_WAIT: counter increments each clock while sampled pressed; any sampled released returns to IDLE, counter cleared, no pulse.
REQ-016 PRESS_WAIT: when counter reaches DEBOUNCE_CYCLES-1 with sampled pressed, go HELD, assert key_press for exactly one clock, set key_level.
REQ-017 HELD: on sampled released, go RELEASE_WAIT with counter cleared; RELEASE_WAIT mirrors PRESS_WAIT (bounce back to HELD without pulse; on count, go IDLE, pulse key_release, clear key_level).
REQ-018 Latency from a clean pin edge to key_press/key_release SHALL be DEBOUNCE_CYCLES+3 clocks.
REQ-019 Counter width SHALL be $clog2 of the largest counted parameter, saturating never wrapping.
REQ-020 Channels SHALL be fully independent; simultaneous presses on several keys SHALL produce pulses in the same cycle.
REQ-021 key_press and key_release SHALL never both be high for the same channel in one cycle.

Reset
REQ-022 On rst_n low all FSMs SHALL go IDLE, counters 0, key_level/key_press/key_release 0.
REQ-023 Synchronizer flops SHALL reset to the released pin level (1 if ACTIVE_LOW) so no spurious press follows reset.
REQ-024 Reset asserted mid-press SHALL discard the press; a key held through reset release SHALL be accepted as a new press after DEBOUNCE_CYCLES+3 clocks.

Configuration
REQ-025 Macro KEY_DEBOUNCE_REPEAT_EN defined: in HELD, after REPEAT_DELAY clocks further key_press pulses every REPEAT_PERIOD clocks until release begins; key_release unaffected.
REQ-026 Macro undefined: exactly one key_press per accepted press; repeat counter and parameters unused and removed.

Structure
REQ-027 Package key_debounce_pkg SHALL hold the FSM state enum and a counter-width constant function.
REQ-028 Sub-module key_debounce_ch SHALL implement one channel (synchronizer, FSM, counters); key_debounce instantiates NUM_KEYS copies via generate.

Verification (DEBOUNCE_CYCLES=16, REPEAT_DELAY=40, REPEAT_PERIOD=10, ACTIVE_LOW=1, NUM_KEYS=5)
REQ-029 key_in[0] 1->0 clean, held 50 clocks -> key_press[0] single pulse at clock 19, key_level[0]=1 from clock 19.
REQ-030 key_in[1] low pulses of 10 clocks separated by 2 clocks high, then high -> no key_press[1], key_level[1] stays 0.
REQ-031 Pressed key_in[2] returns high stable -> key_release[2] pulse 19 clocks after edge, key_level[2]=0.
REQ-032 key_in[3] and key_in[4] pressed same cycle -> key_press=5'b11000 in one cycle.
REQ-033 rst_n pulsed low while key_in[0] low, in PRESS_WAIT -> all outputs 0 during reset; key_press[0] 19 clocks after rst_n release.
REQ-034 With KEY_DEBOUNCE_REPEAT_EN, key_in[0] held 100 clocks -> key_press[0] at clocks 19, 59, 69, 79, 89, 99; without macro only at 19.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debouncer: per-channel FSM state
// and the counter-width calculation used by every channel.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } kd_state_e;

  // Bits needed to hold 0..max_count-1; never narrower than one bit.
  function automatic int unsigned kd_cnt_width(input int unsigned max_count);
    return (max_count > 2) ? int'($clog2(max_count)) : 1;
  endfunction

  function automatic int unsigned kd_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key pin / debounced event bundle between the debouncer and its user.
interface key_debounce_if #(
  parameter int unsigned NUM_KEYS = 5
);

  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One debounced key channel: 3-flop synchronizer, debounce FSM and counters.
// Auto-repeat in the HELD state is built only with KEY_DEBOUNCE_REPEAT_EN.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
`ifdef KEY_DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CW      = kd_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic        IDLE_LVL = ACTIVE_LOW;

  logic [2:0]    sync_q;
  logic          pressed;
  kd_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          press_q;
  logic          release_q;

  // Reset to the released pin level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[1:0], key_i};
    end
  end

  assign pressed = sync_q[2] ^ IDLE_LVL;

  always_comb begin
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int unsigned RW      = kd_cnt_width(kd_max(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_q;
  logic [RW-1:0] rpt_d;
  logic          rpt_first_q;
  logic [RW-1:0] rpt_last;

  always_comb begin
    rpt_d    = (&rpt_q) ? rpt_q : rpt_q + RW'(1);
    rpt_last = rpt_first_q ? RD_LAST : RP_LAST;
  end
`endif

  // The incremented count is compared so the accepting edge is the
  // DEBOUNCE_CYCLES-th consecutive pressed sample, counting the IDLE exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pressed) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!pressed) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_d >= DB_LAST) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
            level_q <= 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_HELD: begin
          if (!pressed) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= '0;
          end
`ifdef KEY_DEBOUNCE_REPEAT_EN
          else if (rpt_q >= rpt_last) begin
            press_q     <= 1'b1;
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
          end else begin
            rpt_q <= rpt_d;
          end
`endif
        end
        ST_RELEASE_WAIT: begin
          if (pressed) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
`endif
          end else if (cnt_d >= DB_LAST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: NUM_KEYS independent key_debounce_ch channels.
// Define KEY_DEBOUNCE_REPEAT_EN to enable auto-repeat press pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
  input logic           clk,
  input logic           rst_n,
  key_debounce_if.slave kif
);

  if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_chk_num_keys
    $error("key_debounce: NUM_KEYS must be 1..32");
  end
  if (DEBOUNCE_CYCLES == 0) begin : g_chk_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_chk_repeat
    $error("key_debounce: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] release_p;

  for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef KEY_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_i     (kif.key_in[g]),
      .level_o   (level[g]),
      .press_o   (press[g]),
      .release_o (release_p[g])
    );
  end

  assign kif.key_level   = level;
  assign kif.key_press   = press;
  assign kif.key_release = release_p;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed sequences, a vector table
// and randomized pin activity against a run-length reference model.
module tb_key_debounce;

  localparam int unsigned N  = 5;
  localparam int unsigned D  = 16;
  localparam int unsigned RD = 40;
  localparam int unsigned RP = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  key_debounce_if #(.NUM_KEYS(N)) kif ();

  key_debounce #(
    .NUM_KEYS        (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1'b1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  // Reference model: a key's level flips once D consecutive samples
  // (pin value seen three clocks earlier) disagree with it.
  logic [N-1:0] pin_hist[$];
  int           run[N];
  int           hold[N];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_release = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] s_raw;
    logic [N-1:0] pr;
    if (!rst_n) begin
      pin_hist.delete();
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      for (int k = 0; k < N; k++) begin
        run[k]  = 0;
        hold[k] = 0;
      end
      return;
    end
    s_raw = (pin_hist.size() < 3) ? '1 : pin_hist[pin_hist.size() - 3];
    pin_hist.push_back(kif.key_in);
    if (pin_hist.size() > 3) void'(pin_hist.pop_front());
    pr        = ~s_raw;
    m_press   = '0;
    m_release = '0;
    for (int k = 0; k < N; k++) begin
      if (pr[k] != m_level[k]) begin
        run[k]++;
        if (run[k] == D) begin
          run[k]     = 0;
          m_level[k] = pr[k];
          if (pr[k]) begin
            m_press[k] = 1'b1;
            hold[k]    = 0;
          end else begin
            m_release[k] = 1'b1;
          end
        end
      end else begin
        if (m_level[k]) begin
          if (run[k] > 0) begin
            hold[k] = 0;
          end else begin
            hold[k]++;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            if (hold[k] == RD || (hold[k] > RD && (hold[k] - RD) % RP == 0))
              m_press[k] = 1'b1;
`endif
          end
        end
        run[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("level",   32'(kif.key_level),   32'(m_level));
    chk("press",   32'(kif.key_press),   32'(m_press));
    chk("release", 32'(kif.key_release), 32'(m_release));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    int key;
    int low_len;
    int exp_press;
    int exp_release;
  } vec_t;

  vec_t vecs[6];
  int   remain[N];
  int   np;
  int   nr;
  bit   want;

  initial begin
    vecs[0] = '{key: 0, low_len: 5,  exp_press: 0, exp_release: 0};
    vecs[1] = '{key: 1, low_len: 15, exp_press: 0, exp_release: 0};
    vecs[2] = '{key: 2, low_len: 16, exp_press: 1, exp_release: 1};
    vecs[3] = '{key: 3, low_len: 17, exp_press: 1, exp_release: 1};
    vecs[4] = '{key: 4, low_len: 30, exp_press: 1, exp_release: 1};
`ifdef KEY_DEBOUNCE_REPEAT_EN
    vecs[5] = '{key: 0, low_len: 60, exp_press: 2, exp_release: 1};
`else
    vecs[5] = '{key: 0, low_len: 60, exp_press: 1, exp_release: 1};
`endif

    rst_n      = 1'b0;
    kif.key_in = '1;
    ticks(3);
    chk("reset_level",   32'(kif.key_level),   32'd0);
    chk("reset_press",   32'(kif.key_press),   32'd0);
    chk("reset_release", 32'(kif.key_release), 32'd0);
    rst_n = 1'b1;
    ticks(5);

    // Clean press on key 0: single pulse 19 clocks after the pin edge.
    kif.key_in[0] = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      chk("k0_press_at19", 32'(kif.key_press[0]), 32'(c == 19));
      chk("k0_level_from19", 32'(kif.key_level[0]), 32'(c >= 19));
    end
    kif.key_in[0] = 1'b1;
    ticks(25);

    // Bouncing key 1 never reaches the debounce count.
    for (int b = 0; b < 3; b++) begin
      kif.key_in[1] = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick();
        chk("k1_bounce_press", 32'(kif.key_press[1]), 32'd0);
      end
      kif.key_in[1] = 1'b1;
      ticks(2);
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("k1_bounce_level", 32'(kif.key_level[1]), 32'd0);
    end

    // Release of key 2: pulse 19 clocks after the rising pin edge.
    kif.key_in[2] = 1'b0;
    ticks(30);
    kif.key_in[2] = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      chk("k2_release_at19", 32'(kif.key_release[2]), 32'(c == 19));
      chk("k2_level_clear", 32'(kif.key_level[2]), 32'(c < 19));
    end

    // Keys 3 and 4 together.
    kif.key_in[4:3] = 2'b00;
    for (int c = 1; c <= 19; c++) begin
      tick();
      chk("k34_same_cycle", 32'(kif.key_press), (c == 19) ? 32'h18 : 32'h0);
    end
    kif.key_in = '1;
    ticks(25);

    // Reset while key 2 is held and key 0 is in its press wait.
    kif.key_in[2] = 1'b0;
    ticks(25);
    kif.key_in[0] = 1'b0;
    ticks(8);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_level",   32'(kif.key_level),   32'd0);
    chk("rst_mid_press",   32'(kif.key_press),   32'd0);
    chk("rst_mid_release", 32'(kif.key_release), 32'd0);
    @(negedge clk);
    ticks(3);
    rst_n = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      chk("post_rst_press", 32'(kif.key_press), (c == 19) ? 32'h05 : 32'h0);
    end
    kif.key_in = '1;
    ticks(25);

    // Long hold on key 0 for the auto-repeat schedule.
    kif.key_in[0] = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      tick();
`ifdef KEY_DEBOUNCE_REPEAT_EN
      want = (c == 19 || c == 59 || c == 69 || c == 79 || c == 89 || c == 99);
`else
      want = (c == 19);
`endif
      chk("k0_repeat", 32'(kif.key_press[0]), 32'(want));
    end
    kif.key_in[0] = 1'b1;
    ticks(25);

    // Vector table: low pulse length vs. pulses produced.
    foreach (vecs[i]) begin
      np = 0;
      nr = 0;
      kif.key_in[vecs[i].key] = 1'b0;
      for (int c = 0; c < vecs[i].low_len; c++) begin
        tick();
        np += int'(kif.key_press[vecs[i].key]);
        nr += int'(kif.key_release[vecs[i].key]);
      end
      kif.key_in[vecs[i].key] = 1'b1;
      for (int c = 0; c < int'(D) + 10; c++) begin
        tick();
        np += int'(kif.key_press[vecs[i].key]);
        nr += int'(kif.key_release[vecs[i].key]);
      end
      chk($sformatf("vec%0d_press_cnt", i), 32'(np), 32'(vecs[i].exp_press));
      chk($sformatf("vec%0d_release_cnt", i), 32'(nr), 32'(vecs[i].exp_release));
      chk($sformatf("vec%0d_level", i), 32'(kif.key_level), 32'd0);
    end

    // Randomized pin activity with occasional resets.
    for (int k = 0; k < N; k++) remain[k] = $urandom_range(1, 60);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (remain[k] == 0) begin
          kif.key_in[k] = ~kif.key_in[k];
          remain[k]     = $urandom_range(1, 60);
        end else begin
          remain[k]--;
        end
      end
      rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst_n      = 1'b1;
    kif.key_in = '1;
    ticks(25);
    chk("final_level", 32'(kif.key_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
